aes_enc_arbiter: RTL and testbench

Sequencer and two-port arbiter in front of one shared table-based AES-128 encryption core. It accepts encrypt requests (key + plaintext) from two requesters and arbitrates between them round-robin. It drives the core's key-load and data-start strobes, waits for completion and returns the ciphertext tagged with the requester ID. It sits between the bus/host-side requesters and the encryption core instance, and is the only block that drives the core's control inputs.

---
 rtl/aes_enc_arbiter.sv | 161 ++++++++++++++++
 tb/tb_aes_enc_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_arbiter.sv
// Round-robin two-port sequencer in front of one shared AES-128 core.
// Define AES_ARB_KEYCACHE_EN to add the single-entry key cache.
module aes_enc_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [127:0]     req_key0,
    input  logic [127:0]     req_key1,
    input  logic [127:0]     req_din0,
    input  logic [127:0]     req_din1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [127:0]     rsp_dout,
    output logic [127:0]     core_kin,
    output logic [127:0]     core_din,
    output logic             core_krdy,
    output logic             core_drdy,
    output logic             core_en,
    output logic             core_rstn,
    input  logic [127:0]     core_dout,
    input  logic             core_bsy,
    input  logic             core_dvld,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_DATA,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_ptr;
    logic             r_id;
    logic [127:0]     r_kin;
    logic [127:0]     r_din;
    logic [127:0]     r_dout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_gnt_id;
    logic [127:0]     w_sel_key;
    logic [127:0]     w_sel_din;
    logic             w_hit;
    logic             w_accept;
    logic             w_done;

    // Both pending: pointer decides; otherwise the lone requester wins
    always_comb begin
        if (req_valid == 2'b11)
            w_gnt_id = r_ptr;
        else
            w_gnt_id = req_valid[1];
    end

    assign w_sel_key = w_gnt_id ? req_key1 : req_key0;
    assign w_sel_din = w_gnt_id ? req_din1 : req_din0;

`ifdef AES_ARB_KEYCACHE_EN
    logic [127:0] r_ckey;
    logic         r_cvld;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ckey <= '0;
            r_cvld <= 1'b0;
        end else if (r_state == S_KEY) begin
            r_ckey <= r_kin;
            r_cvld <= 1'b1;
        end
    end

    assign w_hit = r_cvld && (r_ckey == w_sel_key);
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 2'b00;
        core_krdy = 1'b0;
        core_drdy = 1'b0;
        w_accept  = 1'b0;
        w_done    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    req_ready[w_gnt_id] = 1'b1;
                    w_accept            = 1'b1;
                    w_next              = w_hit ? S_DATA : S_KEY;
                end
            end
            S_KEY: begin
                core_krdy = 1'b1;
                w_next    = S_DATA;
            end
            S_DATA: begin
                core_drdy = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (!core_bsy && core_dvld) begin
                    w_done = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr <= 1'b0;
            r_id  <= 1'b0;
            r_kin <= '0;
            r_din <= '0;
        end else if (w_accept) begin
            r_ptr <= ~w_gnt_id;
            r_id  <= w_gnt_id;
            r_kin <= w_sel_key;
            r_din <= w_sel_din;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dout <= '0;
            r_cnt  <= '0;
        end else if (w_done) begin
            r_dout <= core_dout;
            r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_dout  = r_dout;
    assign core_kin  = r_kin;
    assign core_din  = r_din;
    assign core_en   = 1'b1;
    assign core_rstn = ~RST;
    assign done_cnt  = r_cnt;

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Directed bench for aes_enc_arbiter with a cycle-accurate AES core stand-in.
// Core stand-in returns known FIPS-197 / SP800-38A ciphertexts by table.
module tb_aes_enc_arbiter;

    localparam int CW = 2;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;

`ifdef AES_ARB_KEYCACHE_EN
    localparam int HIT_LAT = 13;
    localparam int HIT_KR  = 0;
`else
    localparam int HIT_LAT = 14;
    localparam int HIT_KR  = 1;
`endif

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [1:0]     req_valid = 2'b00;
    logic [1:0]     req_ready;
    logic [127:0]   req_key0 = '0;
    logic [127:0]   req_key1 = '0;
    logic [127:0]   req_din0 = '0;
    logic [127:0]   req_din1 = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic           rsp_id;
    logic [127:0]   rsp_dout;
    logic [127:0]   core_kin;
    logic [127:0]   core_din;
    logic           core_krdy;
    logic           core_drdy;
    logic           core_en;
    logic           core_rstn;
    logic [127:0]   core_dout;
    logic           core_bsy;
    logic           core_dvld;
    logic [CW-1:0]  done_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int rr_bad = 0;

    always #5 CLK = ~CLK;

    aes_enc_arbiter #(.CNT_W(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key0  (req_key0),
        .req_key1  (req_key1),
        .req_din0  (req_din0),
        .req_din1  (req_din1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_dout  (rsp_dout),
        .core_kin  (core_kin),
        .core_din  (core_din),
        .core_krdy (core_krdy),
        .core_drdy (core_drdy),
        .core_en   (core_en),
        .core_rstn (core_rstn),
        .core_dout (core_dout),
        .core_bsy  (core_bsy),
        .core_dvld (core_dvld),
        .done_cnt  (done_cnt)
    );

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] d);
        if (k == K0 && d == P0) return C0;
        if (k == K1 && d == P1) return C1;
        return k ^ d;
    endfunction

    // Core stand-in: busy 10 cycles after the data strobe, then level valid
    logic [127:0] m_key;
    logic [127:0] m_din;
    logic [3:0]   m_cnt;

    always_ff @(posedge CLK or negedge core_rstn) begin
        if (!core_rstn) begin
            m_key     <= '0;
            m_din     <= '0;
            m_cnt     <= '0;
            core_bsy  <= 1'b0;
            core_dvld <= 1'b0;
            core_dout <= '0;
        end else begin
            if (core_krdy)
                m_key <= core_kin;
            if (core_drdy) begin
                m_din     <= core_din;
                m_cnt     <= 4'd9;
                core_bsy  <= 1'b1;
                core_dvld <= 1'b0;
            end else if (core_bsy) begin
                if (m_cnt == 4'd0) begin
                    core_bsy  <= 1'b0;
                    core_dvld <= 1'b1;
                    core_dout <= aes_ref(m_key, m_din);
                end else begin
                    m_cnt <= m_cnt - 4'd1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issues one request; returns at the negedge where rsp_valid is first seen
    task automatic do_req(input int id, input logic [127:0] key, input logic [127:0] din,
                          output int lat, output int nkr);
        int got;
        lat = -1;
        nkr = 0;
        got = 0;
        @(negedge CLK);
        if (id == 0) begin
            req_key0 = key;
            req_din0 = din;
        end else begin
            req_key1 = key;
            req_din1 = din;
        end
        req_valid[id] = 1'b1;
        for (int i = 0; i < 40 && got == 0; i++) begin
            #1;
            if (req_ready[id]) got = 1;
            else @(negedge CLK);
        end
        chk("accept", got, 1);
        @(posedge CLK);
        #1;
        req_valid[id] = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge CLK);
            if (core_krdy) nkr++;
            if (req_ready != 2'b00) rr_bad++;
            if (rsp_valid) lat = k;
        end
    endtask

    task automatic pulse_rst();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        int lat;
        int nkr;
        int bad;
        int bad_rr;
        int got;
        logic [127:0] d0;
        logic         i0;

        // Power-on reset state
        repeat (2) @(negedge CLK);
        chk("rst_core_rstn", core_rstn, 0);
        RST = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_dout", rsp_dout, 0);
        chk("rst_core_kin", core_kin, 0);
        chk("rst_core_din", core_din, 0);
        chk("rst_strobes", {core_krdy, core_drdy}, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("core_en", core_en, 1);
        chk("core_rstn_run", core_rstn, 1);

        // Single miss from requester 0
        do_req(0, K0, P0, lat, nkr);
        chk("miss_lat", lat, 14);
        chk("miss_krdy", nkr, 1);
        chk("miss_dout", rsp_dout, C0);
        chk("miss_id", rsp_id, 0);
        chk("miss_cnt", done_cnt, 1);
        @(posedge CLK);
        #1;
        chk("miss_rsp_drop", rsp_valid, 0);

        // Same key from requester 1
        do_req(1, K0, P0, lat, nkr);
        chk("hit_lat", lat, HIT_LAT);
        chk("hit_krdy", nkr, HIT_KR);
        chk("hit_dout", rsp_dout, C0);
        chk("hit_id", rsp_id, 1);
        chk("hit_cnt", done_cnt, 2);
        chk("busy_req_ready", rr_bad, 0);
        @(posedge CLK);
        #1;

        // Backpressure with a competing request pending
        rsp_ready = 1'b0;
        do_req(0, K0, P0, lat, nkr);
        d0 = rsp_dout;
        i0 = rsp_id;
        chk("bp_dout", d0, C0);
        chk("bp_id", i0, 0);
        chk("bp_cnt", done_cnt, 3);
        req_key1 = K1;
        req_din1 = P1;
        req_valid[1] = 1'b1;
        bad = 0;
        bad_rr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!rsp_valid || rsp_dout !== d0 || rsp_id !== i0) bad++;
            if (req_ready != 2'b00) bad_rr++;
        end
        chk("bp_stable", bad, 0);
        chk("bp_req_ready", bad_rr, 0);
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_release", rsp_valid, 0);
        chk("bp_next_gnt", req_ready, 2'b10);
        @(posedge CLK);
        #1;
        req_valid[1] = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            @(negedge CLK);
            if (rsp_valid) got = 1;
        end
        chk("bp2_seen", got, 1);
        chk("bp2_dout", rsp_dout, C1);
        chk("bp2_id", rsp_id, 1);
        chk("cnt_wrap", done_cnt, 0);
        @(posedge CLK);
        #1;

        // Reset in cycle 6 of a miss (cache holds K1, so K0 misses)
        @(negedge CLK);
        req_key0 = K0;
        req_din0 = P0;
        req_valid[0] = 1'b1;
        #1;
        chk("mid_accept", req_ready, 2'b01);
        @(posedge CLK);
        #1;
        req_valid[0] = 1'b0;
        repeat (6) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("mid_core_rstn", core_rstn, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_dout", rsp_dout, 0);
        chk("mid_core_kin", core_kin, 0);
        chk("mid_core_din", core_din, 0);
        chk("mid_strobes", {core_krdy, core_drdy}, 0);
        chk("mid_done_cnt", done_cnt, 0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (rsp_valid) bad++;
        end
        chk("mid_no_rsp", bad, 0);
        do_req(0, K0, P0, lat, nkr);
        chk("post_rst_lat", lat, 14);
        chk("post_rst_krdy", nkr, 1);
        chk("post_rst_dout", rsp_dout, C0);
        chk("post_rst_cnt", done_cnt, 1);
        @(posedge CLK);
        #1;

        // Contention from reset: both requesters always pending
        pulse_rst();
        req_key0 = K0;
        req_din0 = P0;
        req_key1 = K1;
        req_din1 = P1;
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            got = 0;
            for (int i = 0; i < 40 && got == 0; i++) begin
                #1;
                if (req_ready != 2'b00) got = 1;
                else @(negedge CLK);
            end
            chk("cont_gnt", req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge CLK);
            got = 0;
            for (int i = 0; i < 40 && got == 0; i++) begin
                @(negedge CLK);
                if (rsp_valid) got = 1;
            end
            chk("cont_seen", got, 1);
            chk("cont_id", rsp_id, g % 2);
            chk("cont_dout", rsp_dout, (g % 2 == 0) ? C0 : C1);
            chk("cont_cnt", done_cnt, (g + 1) % 4);
        end
        req_valid = 2'b00;
        repeat (2) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
